// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe
// Pipelined Rijndael ShiftRows / InvShiftRows stage with a valid/ready
// handshake and a two-entry output buffer (output register O plus skid
// register S), so back-pressure never drops or corrupts a state.
//
// Block width: NB = 4, 6 or 8 columns of 32 bits. Column c sits in
// in_data[32*NB-1-32c -: 32]; row r is byte [31-8r -: 8] of that column.
//
// Optional feature macro: SHIFT_ROWS_TAG_EN
//   defined   -> in_tag/out_tag ports exist; the tag rides through O and S
//                in lock-step with the data.
//   undefined -> no tag ports or tag registers; data path is unchanged.
//
// Buffer states (ov,sv):
//   state | meaning
//   EMPTY | (0,0) nothing buffered, in_ready high
//   ONE   | (1,0) O holds the head item, S free
//   FULL  | (1,1) O and S both hold items, in_ready low
//   (0,1) is never entered: S only fills while O is occupied, and S moves
//   into O before O is allowed to go empty.

module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*NB-1:0]    in_data,
    input  logic                in_inv,
`ifdef SHIFT_ROWS_TAG_EN
    input  logic [TAG_W-1:0]    in_tag,
    output logic [TAG_W-1:0]    out_tag,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NB-1:0]    out_data,
    output logic [1:0]          occ
);

    localparam int W = 32 * NB;

    // Reject illegal geometries at elaboration time.
    generate
        if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (TAG_W < 1) begin : g_bad_tag_w
            $error("shift_rows_pipe: TAG_W must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Permutation: pure wiring, both directions built, one selected.
    // ------------------------------------------------------------------
    logic [W-1:0] w_fwd;
    logic [W-1:0] w_inv;
    logic [W-1:0] w_perm;

    generate
        for (genvar c = 0; c < NB; c++) begin : g_col
            for (genvar r = 0; r < 4; r++) begin : g_row
                // Row offsets: (0,1,2,3) for NB 4/6, (0,1,3,4) for NB 8.
                localparam int OFF   = (r == 0) ? 0 :
                                       (r == 1) ? 1 :
                                       (r == 2) ? ((NB == 8) ? 3 : 2) :
                                                  ((NB == 8) ? 4 : 3);
                localparam int SRC_F = (c + OFF) % NB;
                localparam int SRC_I = (c - OFF + NB) % NB;
                localparam int DST_H = W - 1 - 32 * c - 8 * r;
                localparam int SF_H  = W - 1 - 32 * SRC_F - 8 * r;
                localparam int SI_H  = W - 1 - 32 * SRC_I - 8 * r;

                assign w_fwd[DST_H -: 8] = in_data[SF_H -: 8];
                assign w_inv[DST_H -: 8] = in_data[SI_H -: 8];
            end
        end
    endgenerate

    assign w_perm = in_inv ? w_inv : w_fwd;

    // ------------------------------------------------------------------
    // Buffer control
    // ------------------------------------------------------------------
    logic         r_ov;
    logic         r_sv;
    logic         r_in_ready;
    logic [W-1:0] r_o_data;
    logic [W-1:0] r_s_data;

    logic         w_accept;
    logic         w_drain;
    logic         w_ov_nxt;
    logic         w_sv_nxt;
    logic         w_o_from_s;
    logic         w_o_from_in;
    logic         w_s_from_in;

    // Next-state and load-enable decode, in priority order.
    always_comb begin
        w_accept    = in_valid & r_in_ready;
        w_drain     = r_ov & out_ready;
        w_ov_nxt    = r_ov;
        w_sv_nxt    = r_sv;
        w_o_from_s  = 1'b0;
        w_o_from_in = 1'b0;
        w_s_from_in = 1'b0;

        if (w_drain && r_sv) begin
            // Skid item advances to the head; a new item, if any, backfills S.
            w_o_from_s  = 1'b1;
            w_ov_nxt    = 1'b1;
            w_sv_nxt    = w_accept;
            w_s_from_in = w_accept;
        end else if (w_accept && (!r_ov || w_drain) && !r_sv) begin
            // Head is free (or leaving this edge): new item goes straight to O.
            w_o_from_in = 1'b1;
            w_ov_nxt    = 1'b1;
        end else if (w_accept && r_ov && !w_drain) begin
            // Head is stalled: park the new item in S.
            w_s_from_in = 1'b1;
            w_sv_nxt    = 1'b1;
        end else if (w_drain) begin
            w_ov_nxt = 1'b0;
        end
    end

    // Valid bits and registered in_ready (kept equal to !sv).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ov       <= 1'b0;
            r_sv       <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_ov       <= w_ov_nxt;
            r_sv       <= w_sv_nxt;
            r_in_ready <= ~w_sv_nxt;
        end
    end

    // Data registers; O holds steady unless a load is decoded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_data <= '0;
            r_s_data <= '0;
        end else begin
            if (w_o_from_s) begin
                r_o_data <= r_s_data;
            end else if (w_o_from_in) begin
                r_o_data <= w_perm;
            end
            if (w_s_from_in) begin
                r_s_data <= w_perm;
            end
        end
    end

`ifdef SHIFT_ROWS_TAG_EN
    logic [TAG_W-1:0] r_o_tag;
    logic [TAG_W-1:0] r_s_tag;

    // Tag registers follow exactly the same load enables as the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_tag <= '0;
            r_s_tag <= '0;
        end else begin
            if (w_o_from_s) begin
                r_o_tag <= r_s_tag;
            end else if (w_o_from_in) begin
                r_o_tag <= in_tag;
            end
            if (w_s_from_in) begin
                r_s_tag <= in_tag;
            end
        end
    end

    assign out_tag = r_o_tag;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_ov;
    assign out_data  = r_o_data;
    assign occ       = {1'b0, r_ov} + {1'b0, r_sv};

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: an NB=4 instance carries the main
// traffic (single items, back-pressure, streaming, reset while full) and an
// NB=8 instance checks the wide-block offsets. Tags are checked when
// SHIFT_ROWS_TAG_EN is defined.

module tb_shift_rows_pipe;

    localparam int TAG_W = 4;

    typedef struct {
        logic [127:0]     data;
        logic [TAG_W-1:0] tag;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       in_data;
    logic               in_inv;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       out_data;
    logic [1:0]         occ;

    logic               in_valid8;
    logic               in_ready8;
    logic [255:0]       in_data8;
    logic               in_inv8;
    logic               out_valid8;
    logic               out_ready8;
    logic [255:0]       out_data8;
    logic [1:0]         occ8;

`ifdef SHIFT_ROWS_TAG_EN
    logic [TAG_W-1:0]   in_tag;
    logic [TAG_W-1:0]   out_tag;
    logic [TAG_W-1:0]   in_tag8;
    logic [TAG_W-1:0]   out_tag8;
`endif

    shift_rows_pipe #(.NB(4), .TAG_W(TAG_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
`ifdef SHIFT_ROWS_TAG_EN
        .in_tag    (in_tag),
        .out_tag   (out_tag),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

    shift_rows_pipe #(.NB(8), .TAG_W(TAG_W)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .in_inv    (in_inv8),
`ifdef SHIFT_ROWS_TAG_EN
        .in_tag    (in_tag8),
        .out_tag   (out_tag8),
`endif
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8),
        .occ       (occ8)
    );

    // Hand-computed vectors (NB=4): inputs, forward and inverse results.
    localparam logic [127:0] V0 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] F0 = 128'h00050a0f_04090e03_080d0207_0c01060b;
    localparam logic [127:0] I0 = 128'h000d0a07_04010e0b_0805020f_0c090603;
    localparam logic [127:0] V1 = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [127:0] F1 = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] I1 = 128'hd4415df1_e02752e5_b8bf1130_1eb498ae;
    // NB=8: bytes 00..1f and the forward result (offsets 0,1,3,4).
    localparam logic [255:0] V8 = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [255:0] F8 = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

    item_t        q[$];
    logic [255:0] q8[$];
    item_t        mon_e;
    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int n_out8   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor for the NB=4 instance: pops on every observed transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (!out_valid) chk("skid_without_head", 256'(occ), 256'(0));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected no output", out_data);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_data", 256'(out_data), 256'(mon_e.data));
`ifdef SHIFT_ROWS_TAG_EN
                    chk("out_tag", 256'(out_tag), 256'(mon_e.tag));
`endif
                    n_out++;
                end
            end
        end
    end

    // Monitor for the NB=8 instance.
    always @(negedge clk) begin
        if (!rst && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output8: got %h expected no output", out_data8);
            end else begin
                chk("out_data8", out_data8, q8.pop_front());
                n_out8++;
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic inv,
                        input logic [127:0] exp, input logic [TAG_W-1:0] tag);
        int n = 0;
        item_t it;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
`ifdef SHIFT_ROWS_TAG_EN
        in_tag   = tag;
`endif
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            it.data = exp;
            it.tag  = tag;
            q.push_back(it);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send8(input logic [255:0] d, input logic inv, input logic [255:0] exp);
        int n = 0;
        in_valid8 = 1'b1;
        in_data8  = d;
        in_inv8   = inv;
        while (!in_ready8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready8) begin
            n_checks++;
            n_fail++;
            $display("FAIL send8_timeout: in_ready got 0 expected 1");
        end else begin
            q8.push_back(exp);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || q8.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0 || q8.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: pending got %0d expected 0", q.size() + q8.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int start_cyc;
        int start_out;
        logic [127:0] src;
        logic [127:0] exp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b1;
        in_valid8 = 1'b0;
        in_data8  = '0;
        in_inv8   = 1'b0;
        out_ready8 = 1'b1;
`ifdef SHIFT_ROWS_TAG_EN
        in_tag    = '0;
        in_tag8   = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_in_ready",  256'(in_ready),  256'(1));
        chk("rst_occ",       256'(occ),       256'(0));
        chk("rst_out_data",  256'(out_data),  256'(0));
        chk("rst_out_valid8", 256'(out_valid8), 256'(0));
`ifdef SHIFT_ROWS_TAG_EN
        chk("rst_out_tag",   256'(out_tag),   256'(0));
`endif

        // Single items: one-cycle latency, both modes, FIPS round trip
        send(V0, 1'b0, F0, 4'h1);
        chk("latency_valid", 256'(out_valid), 256'(1));
        chk("latency_data",  256'(out_data),  256'(F0));
        send(V0, 1'b1, I0, 4'h2);
        send(V1, 1'b0, F1, 4'h3);
        send(F1, 1'b1, V1, 4'h4);
        send(V1, 1'b1, I1, 4'h5);
        wait_drain();

        // Wide block
        send8(V8, 1'b0, F8);
        send8(F8, 1'b1, V8);
        wait_drain();

        // Back-pressure: three offered, two accepted, head held stable
        out_ready = 1'b0;
        send(V0, 1'b0, F0, 4'h6);
        send(V0, 1'b1, I0, 4'h7);
        chk("bp_occ_full",  256'(occ),      256'(2));
        chk("bp_in_ready",  256'(in_ready), 256'(0));
        in_valid = 1'b1;
        in_data  = V1;
        in_inv   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_occ_hold",  256'(occ),       256'(2));
        chk("bp_head_hold", 256'(out_data),  256'(F0));
        chk("bp_valid_hold", 256'(out_valid), 256'(1));
        out_ready = 1'b1;
        start_out = n_out;
        send(V1, 1'b0, F1, 4'h8);
        wait_drain();
        chk("bp_delivered", 256'(n_out - start_out), 256'(3));

        // Streaming with alternating mode; occupancy stays at ONE
        start_cyc = cyc;
        start_out = n_out;
        for (int i = 0; i < 16; i++) begin
            src = ((i / 2) % 2 == 0) ? V0 : V1;
            if (i % 2 == 0) exp = ((i / 2) % 2 == 0) ? F0 : F1;
            else            exp = ((i / 2) % 2 == 0) ? I0 : I1;
            send(src, 1'(i % 2), exp, 4'(i));
            chk("stream_occ", 256'(occ), 256'(1));
        end
        chk("stream_cycles", 256'(cyc - start_cyc), 256'(16));
        wait_drain();
        chk("stream_outputs", 256'(n_out - start_out), 256'(16));

        // Reset while FULL discards both items
        out_ready = 1'b0;
        send(V0, 1'b0, F0, 4'h9);
        send(V1, 1'b0, F1, 4'ha);
        chk("pre_rst_occ", 256'(occ), 256'(2));
        in_valid = 1'b1;
        in_data  = V0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        chk("post_rst_occ",       256'(occ),       256'(0));
        chk("post_rst_out_valid", 256'(out_valid), 256'(0));
        chk("post_rst_in_ready",  256'(in_ready),  256'(1));
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_stale_valid", 256'(out_valid), 256'(0));
        start_out = n_out;
        send(V1, 1'b1, I1, 4'hb);
        wait_drain();
        chk("post_rst_outputs", 256'(n_out - start_out), 256'(1));
        chk("wide_outputs", 256'(n_out8), 256'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
